skin_frame_scheduler: RTL and testbench

Frame-level controller for the skintone detector. On a start command it scans a width×height YCbCr frame out of pixel memory in raster order, feeds each pixel to the detector with a valid strobe, and collects the in-order detector scores. It thresholds each score and accumulates frame statistics: skin-pixel count, score sum and skin bounding box. It sits between the frame buffer and the downstream region-of-interest logic.

---
 rtl/skin_frame_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_skin_frame_scheduler.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/skin_frame_scheduler.sv
// Frame scheduler for the skintone detector: raster-scans a YCbCr frame out of pixel memory,
// feeds the detector, and accumulates skin count, score sum and skin bounding box.
module skin_frame_scheduler #(
  parameter int DIM_W         = 10,
  parameter int ADDR_W        = 20,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [DIM_W-1:0]    width,
  input  logic [DIM_W-1:0]    height,
  input  logic [7:0]          threshold,
  input  logic                hold,
  output logic                mem_rd,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [7:0]          mem_Y,
  input  logic [7:0]          mem_Cb,
  input  logic [7:0]          mem_Cr,
  output logic                det_valid_in,
  output logic [7:0]          det_Y,
  output logic [7:0]          det_Cb,
  output logic [7:0]          det_Cr,
  input  logic                det_valid_out,
  input  logic [7:0]          det_skinScore,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [ADDR_W-1:0]   skin_count,
  output logic [ADDR_W+7:0]   score_sum,
  output logic [DIM_W-1:0]    x_min,
  output logic [DIM_W-1:0]    x_max,
  output logic [DIM_W-1:0]    y_min,
  output logic [DIM_W-1:0]    y_max,
  output logic                bbox_valid
);

  localparam int TO_W = $clog2(DRAIN_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t              r_state, w_next;
  logic [DIM_W-1:0]    r_width, r_height, r_x, r_y, r_ox, r_oy;
  logic [DIM_W-1:0]    r_xmin, r_xmax, r_ymin, r_ymax;
  logic [7:0]          r_thr;
  logic [ADDR_W-1:0]   r_iss_cnt, r_skin_cnt;
  logic [ADDR_W+7:0]   r_sum;
  logic                r_out_full, r_error;
  logic [TO_W-1:0]     r_idle_cnt;
  logic                r_rd_p0, r_vld_p1;
  logic [7:0]          r_y_p1, r_cb_p1, r_cr_p1;

  logic w_start, w_zero, w_issue, w_last_issue, w_accept, w_last_res, w_skin, w_timeout;

  assign w_start      = start && (r_state == S_IDLE);
  assign w_zero       = (width == '0) || (height == '0);
  assign w_issue      = (r_state == S_ISSUE) && !hold;
  assign w_last_issue = w_issue && (r_x == r_width - DIM_W'(1)) && (r_y == r_height - DIM_W'(1));
  assign w_accept     = det_valid_out && !r_out_full &&
                        ((r_state == S_ISSUE) || (r_state == S_DRAIN));
  assign w_last_res   = w_accept && (r_ox == r_width - DIM_W'(1)) && (r_oy == r_height - DIM_W'(1));
  assign w_skin       = det_skinScore >= r_thr;
  // Idle counter holds cycles since the last result, so done lands DRAIN_TIMEOUT cycles after it.
  assign w_timeout    = (r_state == S_DRAIN) && !det_valid_out &&
                        (r_idle_cnt == TO_W'(DRAIN_TIMEOUT - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = w_zero ? S_DONE : S_ISSUE;
      S_ISSUE: if (w_last_issue) w_next = S_DRAIN;
      S_DRAIN: if (w_last_res || r_out_full || w_timeout) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_width    <= '0;
      r_height   <= '0;
      r_thr      <= '0;
      r_iss_cnt  <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_ox       <= '0;
      r_oy       <= '0;
      r_out_full <= 1'b0;
      r_idle_cnt <= '0;
      r_error    <= 1'b0;
      r_skin_cnt <= '0;
      r_sum      <= '0;
      r_xmin     <= '1;
      r_ymin     <= '1;
      r_xmax     <= '0;
      r_ymax     <= '0;
      r_rd_p0    <= 1'b0;
      r_vld_p1   <= 1'b0;
      r_y_p1     <= '0;
      r_cb_p1    <= '0;
      r_cr_p1    <= '0;
    end else begin
      r_state <= w_next;
      // p0: read issued last cycle, memory data arrives now; p1: registered detector input
      r_rd_p0  <= w_issue;
      r_vld_p1 <= r_rd_p0;
      if (r_rd_p0) begin
        r_y_p1  <= mem_Y;
        r_cb_p1 <= mem_Cb;
        r_cr_p1 <= mem_Cr;
      end

      if (w_start) begin
        r_width    <= width;
        r_height   <= height;
        r_thr      <= threshold;
        r_iss_cnt  <= '0;
        r_x        <= '0;
        r_y        <= '0;
        r_ox       <= '0;
        r_oy       <= '0;
        r_out_full <= 1'b0;
        r_skin_cnt <= '0;
        r_sum      <= '0;
        r_xmin     <= '1;
        r_ymin     <= '1;
        r_xmax     <= '0;
        r_ymax     <= '0;
      end

      if (w_issue) begin
        r_iss_cnt <= r_iss_cnt + ADDR_W'(1);
        if (r_x == r_width - DIM_W'(1)) begin
          r_x <= '0;
          r_y <= r_y + DIM_W'(1);
        end else begin
          r_x <= r_x + DIM_W'(1);
        end
      end

      if (w_accept) begin
        r_sum <= r_sum + {{ADDR_W{1'b0}}, det_skinScore};
        if (w_skin) begin
          r_skin_cnt <= r_skin_cnt + ADDR_W'(1);
          if (r_ox < r_xmin) r_xmin <= r_ox;
          if (r_ox > r_xmax) r_xmax <= r_ox;
          if (r_oy < r_ymin) r_ymin <= r_oy;
          if (r_oy > r_ymax) r_ymax <= r_oy;
        end
        if (w_last_res) r_out_full <= 1'b1;
        if (r_ox == r_width - DIM_W'(1)) begin
          r_ox <= '0;
          r_oy <= r_oy + DIM_W'(1);
        end else begin
          r_ox <= r_ox + DIM_W'(1);
        end
      end

      if (det_valid_out)               r_idle_cnt <= TO_W'(1);
      else if (w_start)                r_idle_cnt <= '0;
      else if (r_state == S_DRAIN)     r_idle_cnt <= r_idle_cnt + TO_W'(1);

      if (w_start) r_error <= 1'b0;
      if ((det_valid_out && !w_accept) || w_timeout) r_error <= 1'b1;
    end
  end

  assign mem_rd       = w_issue;
  assign mem_addr     = r_iss_cnt;
  assign det_valid_in = r_vld_p1;
  assign det_Y        = r_y_p1;
  assign det_Cb       = r_cb_p1;
  assign det_Cr       = r_cr_p1;
  assign busy         = (r_state == S_ISSUE) || (r_state == S_DRAIN);
  assign done         = (r_state == S_DONE);
  assign error        = r_error;
  assign skin_count   = r_skin_cnt;
  assign score_sum    = r_sum;
  assign x_min        = r_xmin;
  assign x_max        = r_xmax;
  assign y_min        = r_ymin;
  assign y_max        = r_ymax;
  assign bbox_valid   = (r_skin_cnt != '0);

endmodule

// File: tb/tb_skin_frame_scheduler.sv
// Directed bench for skin_frame_scheduler with a pixel memory model and a fixed-latency-3 detector model.
module tb_skin_frame_scheduler;

  localparam int DIM_W = 10;
  localparam int ADDR_W = 20;
  localparam int TO = 64;

  logic              clk = 1'b0;
  logic              rst, start, hold, hold_rand, drop_last;
  logic [DIM_W-1:0]  width, height;
  logic [7:0]        threshold;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_Y, mem_Cb, mem_Cr;
  logic              det_valid_in;
  logic [7:0]        det_Y, det_Cb, det_Cr;
  logic              det_valid_out;
  logic [7:0]        det_skinScore;
  logic              busy, done, error;
  logic [ADDR_W-1:0] skin_count;
  logic [ADDR_W+7:0] score_sum;
  logic [DIM_W-1:0]  x_min, x_max, y_min, y_max;
  logic              bbox_valid;

  skin_frame_scheduler #(.DIM_W(DIM_W), .ADDR_W(ADDR_W), .DRAIN_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .width(width), .height(height),
    .threshold(threshold), .hold(hold), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_Y(mem_Y), .mem_Cb(mem_Cb), .mem_Cr(mem_Cr), .det_valid_in(det_valid_in),
    .det_Y(det_Y), .det_Cb(det_Cb), .det_Cr(det_Cr), .det_valid_out(det_valid_out),
    .det_skinScore(det_skinScore), .busy(busy), .done(done), .error(error),
    .skin_count(skin_count), .score_sum(score_sum), .x_min(x_min), .x_max(x_max),
    .y_min(y_min), .y_max(y_max), .bbox_valid(bbox_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  logic [7:0] pix_y [128];
  logic [7:0] pix_cb[128];
  logic [7:0] pix_cr[128];

  task automatic set_all(input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr);
    for (int i = 0; i < 128; i++) begin
      pix_y[i] = y; pix_cb[i] = cb; pix_cr[i] = cr;
    end
  endtask

  function automatic logic [7:0] score_f(input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr);
    return (y == 8'd85 && cb == 8'd155 && cr == 8'd110) ? 8'd254 : 8'd0;
  endfunction

  // Models and monitor, all evaluated mid-cycle
  int ncyc = 0, t_start = 0, first_rd = 0, first_dvi = 0, done_cyc = 0, last_res_cyc = 0;
  int n_rd = 0, n_dvi = 0, n_res = 0, done_cnt = 0, data_err = 0;
  int addr_q[$];
  logic pend = 1'b0;
  int paddr = 0;
  logic d0v = 1'b0, d1v = 1'b0, d2v = 1'b0;
  logic [7:0] d0s = '0, d1s = '0, d2s = '0;

  always @(negedge clk) begin
    ncyc++;
    if (rst) begin
      pend = 1'b0; d0v = 1'b0; d1v = 1'b0; d2v = 1'b0;
      det_valid_out = 1'b0;
    end else begin
      if (start && !busy && !done) begin
        t_start = ncyc; n_rd = 0; n_dvi = 0; n_res = 0; done_cnt = 0; data_err = 0;
        addr_q.delete();
      end
      if (mem_rd) begin
        if (n_rd == 0) first_rd = ncyc;
        addr_q.push_back(int'(mem_addr));
        n_rd++;
      end
      det_valid_out = d2v; det_skinScore = d2s;
      d2v = d1v; d2s = d1s; d1v = d0v; d1s = d0s;
      d0v = det_valid_in && !(drop_last && n_dvi == 7);
      d0s = score_f(det_Y, det_Cb, det_Cr);
      if (det_valid_in) begin
        if (n_dvi == 0) first_dvi = ncyc;
        if (n_dvi >= addr_q.size()) data_err++;
        else if (det_Y !== pix_y[addr_q[n_dvi] & 127] || det_Cb !== pix_cb[addr_q[n_dvi] & 127] ||
                 det_Cr !== pix_cr[addr_q[n_dvi] & 127]) data_err++;
        n_dvi++;
      end
      if (det_valid_out) begin n_res++; last_res_cyc = ncyc; end
      if (done) begin done_cnt++; done_cyc = ncyc; end
      if (pend) begin
        mem_Y = pix_y[paddr & 127]; mem_Cb = pix_cb[paddr & 127]; mem_Cr = pix_cr[paddr & 127];
      end
      pend = mem_rd; paddr = int'(mem_addr);
    end
  end

  always @(posedge clk) begin
    #2;
    hold = hold_rand ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic start_frame(input int w, input int h, input int thr);
    width = DIM_W'(w); height = DIM_W'(h); threshold = 8'(thr);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin tick(); n++; end
    check_eq(tag, done_cnt > 0, 1);
    repeat (4) tick();
  endtask

  task automatic check_addr_seq(input string tag, input int n);
    int bad = 0;
    for (int i = 0; i < addr_q.size(); i++) if (addr_q[i] != i) bad++;
    check_eq({tag, "_addr_bad"}, bad, 0);
    check_eq({tag, "_n_rd"}, n_rd, n);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; width = '0; height = '0; threshold = '0;
    hold_rand = 1'b0; drop_last = 1'b0; hold = 1'b0;
    det_valid_out = 1'b0; det_skinScore = '0; mem_Y = '0; mem_Cb = '0; mem_Cr = '0;
    set_all(8'd85, 8'd155, 8'd110);
    repeat (3) tick();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_mem_rd", mem_rd, 0);
    check_eq("rst_dvi", det_valid_in, 0);
    check_eq("rst_error", error, 0);
    check_eq("rst_skin", skin_count, 0);
    check_eq("rst_sum", score_sum, 0);
    check_eq("rst_xmin", x_min, 10'h3FF);
    check_eq("rst_ymin", y_min, 10'h3FF);
    check_eq("rst_xmax", x_max, 0);
    check_eq("rst_bbv", bbox_valid, 0);
    rst = 1'b0;
    tick();

    // 4x2 all-skin frame
    start_frame(4, 2, 128);
    wait_done("t1_done", 100);
    check_eq("t1_first_rd", first_rd - t_start, 1);
    check_eq("t1_first_dvi", first_dvi - t_start, 3);
    check_eq("t1_done_lat", done_cyc - last_res_cyc, 1);
    check_eq("t1_done_cnt", done_cnt, 1);
    check_addr_seq("t1", 8);
    check_eq("t1_data", data_err, 0);
    check_eq("t1_skin", skin_count, 8);
    check_eq("t1_sum", score_sum, 2032);
    check_eq("t1_xmin", x_min, 0);
    check_eq("t1_xmax", x_max, 3);
    check_eq("t1_ymin", y_min, 0);
    check_eq("t1_ymax", y_max, 1);
    check_eq("t1_bbv", bbox_valid, 1);
    check_eq("t1_error", error, 0);
    check_eq("t1_busy", busy, 0);

    // 3x3 frame, skin only at the centre pixel
    set_all(8'd250, 8'd0, 8'd0);
    pix_y[4] = 8'd85; pix_cb[4] = 8'd155; pix_cr[4] = 8'd110;
    start_frame(3, 3, 1);
    wait_done("t2_done", 100);
    check_addr_seq("t2", 9);
    check_eq("t2_skin", skin_count, 1);
    check_eq("t2_sum", score_sum, 254);
    check_eq("t2_xmin", x_min, 1);
    check_eq("t2_xmax", x_max, 1);
    check_eq("t2_ymin", y_min, 1);
    check_eq("t2_ymax", y_max, 1);
    check_eq("t2_error", error, 0);

    // 4x2 frame with random hold bubbles
    set_all(8'd85, 8'd155, 8'd110);
    hold_rand = 1'b1;
    start_frame(4, 2, 128);
    wait_done("t3_done", 500);
    hold_rand = 1'b0;
    check_addr_seq("t3", 8);
    check_eq("t3_data", data_err, 0);
    check_eq("t3_skin", skin_count, 8);
    check_eq("t3_sum", score_sum, 2032);
    check_eq("t3_xmax", x_max, 3);
    check_eq("t3_ymax", y_max, 1);
    check_eq("t3_error", error, 0);
    tick();

    // zero-width frame
    start_frame(0, 2, 128);
    wait_done("t4_done", 20);
    check_eq("t4_done_lat", done_cyc - t_start, 1);
    check_eq("t4_n_rd", n_rd, 0);
    check_eq("t4_skin", skin_count, 0);
    check_eq("t4_sum", score_sum, 0);
    check_eq("t4_bbv", bbox_valid, 0);
    check_eq("t4_done_cnt", done_cnt, 1);

    // start while busy is ignored
    start_frame(4, 2, 128);
    repeat (2) tick();
    width = 10'd1; height = 10'd1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t4b_done", 100);
    check_addr_seq("t4b", 8);
    check_eq("t4b_skin", skin_count, 8);
    check_eq("t4b_done_cnt", done_cnt, 1);

    // detector drops the last result
    drop_last = 1'b1;
    start_frame(4, 2, 128);
    wait_done("t5_done", 300);
    drop_last = 1'b0;
    check_eq("t5_n_res", n_res, 7);
    check_eq("t5_error", error, 1);
    check_eq("t5_to_lat", done_cyc - last_res_cyc, TO);
    check_eq("t5_skin", skin_count, 7);
    check_eq("t5_done_cnt", done_cnt, 1);

    // reset in the middle of a 10x10 frame
    start_frame(10, 10, 128);
    repeat (20) tick();
    check_eq("t6_busy_pre", busy, 1);
    rst = 1'b1;
    #1;
    check_eq("t6_busy", busy, 0);
    check_eq("t6_mem_rd", mem_rd, 0);
    check_eq("t6_skin", skin_count, 0);
    check_eq("t6_sum", score_sum, 0);
    check_eq("t6_xmin", x_min, 10'h3FF);
    check_eq("t6_ymax", y_max, 0);
    check_eq("t6_error", error, 0);
    tick(); tick();
    rst = 1'b0;
    repeat (4) tick();
    check_eq("t6_no_done", done_cnt, 0);
    check_eq("t6_dvi", det_valid_in, 0);
    start_frame(2, 2, 128);
    wait_done("t6b_done", 100);
    check_addr_seq("t6b", 4);
    check_eq("t6b_skin", skin_count, 4);
    check_eq("t6b_sum", score_sum, 1016);
    check_eq("t6b_xmax", x_max, 1);
    check_eq("t6b_ymax", y_max, 1);
    check_eq("t6b_error", error, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
